sys_array_tile_sequencer: RTL

//  Runtime-dimensioned, tiled operand sequencer for an external output-stationary P x Q systolic array.

---
 rtl/sys_array_tile_sequencer_if.sv | 59 +++++
 rtl/sys_array_tile_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sys_array_tile_sequencer_if.sv
// Operand-fetch / array-control / result-handshake bundle for sys_array_tile_sequencer.
// master: the sequencer.  slave: buffers, array and result drain around it.
// Optional perf counters appear when SYS_FETCH_PERF_CNT_EN is defined.
interface sys_array_tile_sequencer_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int ARRAY_MAX_W = 5,
  parameter int ARRAY_MAX_L = 5,
  parameter int DIM_W       = 16,
  parameter int ADDR_W      = 16
);
  localparam int RW = $clog2(ARRAY_MAX_W + 1);
  localparam int CW = $clog2(ARRAY_MAX_L + 1);

  logic                              start;
  logic [DIM_W-1:0]                  cfg_m;
  logic [DIM_W-1:0]                  cfg_n;
  logic [DIM_W-1:0]                  cfg_k;
  logic                              a_rd_en;
  logic [ADDR_W-1:0]                 a_rd_addr;
  logic [ARRAY_MAX_W*DATA_WIDTH-1:0] a_rd_data;
  logic                              b_rd_en;
  logic [ADDR_W-1:0]                 b_rd_addr;
  logic [ARRAY_MAX_L*DATA_WIDTH-1:0] b_rd_data;
  logic [ARRAY_MAX_W*DATA_WIDTH-1:0] arr_a;
  logic [ARRAY_MAX_L*DATA_WIDTH-1:0] arr_b;
  logic                              arr_en;
  logic                              arr_clr;
  logic                              res_valid;
  logic                              res_ready;
  logic [DIM_W-1:0]                  res_mt;
  logic [DIM_W-1:0]                  res_nt;
  logic [RW-1:0]                     res_rows;
  logic [CW-1:0]                     res_cols;
  logic                              busy;
  logic                              done;
  logic                              err;
`ifdef SYS_FETCH_PERF_CNT_EN
  logic [31:0]                       perf_cycles;
  logic [31:0]                       perf_stall;
`endif

  modport master (
`ifdef SYS_FETCH_PERF_CNT_EN
    output perf_cycles, perf_stall,
`endif
    input  start, cfg_m, cfg_n, cfg_k, a_rd_data, b_rd_data, res_ready,
    output a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, arr_a, arr_b, arr_en, arr_clr,
           res_valid, res_mt, res_nt, res_rows, res_cols, busy, done, err
  );

  modport slave (
`ifdef SYS_FETCH_PERF_CNT_EN
    input  perf_cycles, perf_stall,
`endif
    output start, cfg_m, cfg_n, cfg_k, a_rd_data, b_rd_data, res_ready,
    input  a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, arr_a, arr_b, arr_en, arr_clr,
           res_valid, res_mt, res_nt, res_rows, res_cols, busy, done, err
  );
endinterface

// File: rtl/sys_array_tile_sequencer.sv
// Tiled operand sequencer for an output-stationary P x Q systolic array.
// Walks tiles (nt inner, mt outer), streams K operand columns per tile,
// zero-pads rows/cols past the matrix edge, skews them diagonally and
// hands each finished tile to the drain over res_valid/res_ready.
// Optional: define SYS_FETCH_PERF_CNT_EN for perf_cycles/perf_stall counters.
module sys_array_tile_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int ARRAY_MAX_W = 5,
  parameter int ARRAY_MAX_L = 5,
  parameter int K_MAX       = 64,
  parameter int DIM_W       = 16,
  parameter int ADDR_W      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  sys_array_tile_sequencer_if.master  bus
);
  localparam int P  = ARRAY_MAX_W;
  localparam int Q  = ARRAY_MAX_L;
  localparam int RW = $clog2(P + 1);
  localparam int CW = $clog2(Q + 1);
  localparam logic [DIM_W-1:0]  P_D          = DIM_W'(P);
  localparam logic [DIM_W-1:0]  Q_D          = DIM_W'(Q);
  localparam logic [DIM_W-1:0]  KMAX_D       = DIM_W'(K_MAX);
  localparam logic [DIM_W-1:0]  FLUSH_LAST_D = DIM_W'(P + Q - 2);
  localparam logic [DIM_W-1:0]  ONE_D        = DIM_W'(1);
  localparam logic [ADDR_W-1:0] KMAX_A       = ADDR_W'(K_MAX);

  typedef enum logic [2:0] {S_IDLE, S_FEED, S_FLUSH, S_WAIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [DIM_W-1:0] cnt_q, cnt_d;   // k index in FEED, flush index in FLUSH
  logic [DIM_W-1:0] mt_q, mt_d;
  logic [DIM_W-1:0] nt_q, nt_d;
  logic [DIM_W-1:0] m_q, m_d;
  logic [DIM_W-1:0] n_q, n_d;
  logic [DIM_W-1:0] k_q, k_d;
  logic             err_q, err_d;
  logic             vld_p1_q;       // read data returning this cycle

  logic             cfg_ok, accept;
  logic [DIM_W-1:0] rem_m, rem_n;
  logic             last_mt, last_nt;
  logic [RW-1:0]    rows;
  logic [CW-1:0]    cols;

  assign cfg_ok = (bus.cfg_m != '0) && (bus.cfg_n != '0) &&
                  (bus.cfg_k != '0) && (bus.cfg_k <= KMAX_D);
  assign accept = (state_q == S_IDLE) && bus.start && cfg_ok;

  // Remaining rows/cols from the current tile origin; always > 0 inside a job.
  assign rem_m   = m_q - mt_q * P_D;
  assign rem_n   = n_q - nt_q * Q_D;
  assign last_mt = (rem_m <= P_D);
  assign last_nt = (rem_n <= Q_D);
  assign rows    = (rem_m >= P_D) ? P_D[RW-1:0] : rem_m[RW-1:0];
  assign cols    = (rem_n >= Q_D) ? Q_D[CW-1:0] : rem_n[CW-1:0];

  // Next-state and counter logic for the tile walk.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mt_d    = mt_q;
    nt_d    = nt_q;
    m_d     = m_q;
    n_d     = n_q;
    k_d     = k_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_FEED;
          m_d     = bus.cfg_m;
          n_d     = bus.cfg_n;
          k_d     = bus.cfg_k;
          cnt_d   = '0;
          mt_d    = '0;
          nt_d    = '0;
        end else if (bus.start) begin
          err_d = 1'b1;
        end
      end
      S_FEED: begin
        if (cnt_q == k_q - ONE_D) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_D;
        end
      end
      S_FLUSH: begin
        if (cnt_q == FLUSH_LAST_D) begin
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + ONE_D;
        end
      end
      S_WAIT: begin
        if (bus.res_ready) begin
          cnt_d = '0;
          if (last_nt) begin
            if (last_mt) begin
              state_d = S_DONE;
            end else begin
              state_d = S_FEED;
              nt_d    = '0;
              mt_d    = mt_q + ONE_D;
            end
          end else begin
            state_d = S_FEED;
            nt_d    = nt_q + ONE_D;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        mt_d    = '0;
        nt_d    = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mt_q     <= '0;
      nt_q     <= '0;
      m_q      <= '0;
      n_q      <= '0;
      k_q      <= '0;
      err_q    <= 1'b0;
      vld_p1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mt_q     <= mt_d;
      nt_q     <= nt_d;
      m_q      <= m_d;
      n_q      <= n_d;
      k_q      <= k_d;
      err_q    <= err_d;
      vld_p1_q <= (state_q == S_FEED);
    end
  end

  // ---- stage p0: read request ----
  assign bus.a_rd_en   = (state_q == S_FEED);
  assign bus.b_rd_en   = (state_q == S_FEED);
  assign bus.a_rd_addr = ADDR_W'(mt_q) * KMAX_A + ADDR_W'(cnt_q);
  assign bus.b_rd_addr = ADDR_W'(nt_q) * KMAX_A + ADDR_W'(cnt_q);
  assign bus.arr_en    = (state_q == S_FEED) || (state_q == S_FLUSH);
  assign bus.arr_clr   = (state_q == S_FEED) && (cnt_q == '0);
  assign bus.res_valid = (state_q == S_WAIT);
  assign bus.res_mt    = mt_q;
  assign bus.res_nt    = nt_q;
  assign bus.res_rows  = rows;
  assign bus.res_cols  = cols;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.err       = err_q;

  // ---- stage p1: read return, edge padding, then per-lane skew ----
  logic [P*DATA_WIDTH-1:0] arr_a_w;
  logic [Q*DATA_WIDTH-1:0] arr_b_w;

  for (genvar i = 0; i < P; i++) begin : g_row
    logic [DATA_WIDTH-1:0] pad_a;
    assign pad_a = (vld_p1_q && (RW'(i) < rows)) ?
                   bus.a_rd_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (i == 0) begin : g_direct
      assign arr_a_w[i*DATA_WIDTH +: DATA_WIDTH] = pad_a;
    end else begin : g_skew
      logic [DATA_WIDTH-1:0] sr_q [i];
      // Row i delayed i cycles; zeros shift in outside valid reads.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int d = 0; d < i; d++) sr_q[d] <= '0;
        end else begin
          sr_q[0] <= pad_a;
          for (int d = 1; d < i; d++) sr_q[d] <= sr_q[d-1];
        end
      end
      assign arr_a_w[i*DATA_WIDTH +: DATA_WIDTH] = sr_q[i-1];
    end
  end

  for (genvar j = 0; j < Q; j++) begin : g_col
    logic [DATA_WIDTH-1:0] pad_b;
    assign pad_b = (vld_p1_q && (CW'(j) < cols)) ?
                   bus.b_rd_data[j*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (j == 0) begin : g_direct
      assign arr_b_w[j*DATA_WIDTH +: DATA_WIDTH] = pad_b;
    end else begin : g_skew
      logic [DATA_WIDTH-1:0] sr_q [j];
      // Column j delayed j cycles; zeros shift in outside valid reads.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int d = 0; d < j; d++) sr_q[d] <= '0;
        end else begin
          sr_q[0] <= pad_b;
          for (int d = 1; d < j; d++) sr_q[d] <= sr_q[d-1];
        end
      end
      assign arr_b_w[j*DATA_WIDTH +: DATA_WIDTH] = sr_q[j-1];
    end
  end

  assign bus.arr_a = arr_a_w;
  assign bus.arr_b = arr_b_w;

`ifdef SYS_FETCH_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] perf_cycles_q, perf_stall_q;

  // Job cycle and drain-stall counters; the accept cycle counts as cycle 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else if (accept) begin
      perf_cycles_q <= 32'd1;
      perf_stall_q  <= '0;
    end else begin
      if (state_q != S_IDLE) perf_cycles_q <= sat_inc(perf_cycles_q);
      if ((state_q == S_WAIT) && !bus.res_ready) perf_stall_q <= sat_inc(perf_stall_q);
    end
  end

  assign bus.perf_cycles = perf_cycles_q;
  assign bus.perf_stall  = perf_stall_q;
`endif
endmodule
